// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and helpers for the pipeline hazard unit.
//   hz_entry_t     one scoreboard entry (in-flight writer)
//   hz_pos_t       fixed-size view of scoreboard positions 1..HZ_DEPTH_MAX
//   FWD_NONE       forward select meaning "use ID/EX register data"
//   youngest_match priority search over positions 1..depth-1
package pipe_pkg;

    // Upper bounds for the parametrised top; entries are stored at these widths.
    localparam int HZ_ADDR_W_MAX = 8;
    localparam int HZ_DEPTH_MAX  = 8;
    localparam int FWD_NONE      = 0;

    typedef struct packed {
        logic                     valid;
        logic [HZ_ADDR_W_MAX-1:0] dst;
        logic                     reg_write;
        logic                     is_load;
        logic                     flag_write;
    } hz_entry_t;

    typedef hz_entry_t [HZ_DEPTH_MAX:1] hz_pos_t;

    // Returns the smallest (youngest) position p in 1..depth-1 whose writer
    // targets src, or FWD_NONE. Position depth is retiring and is covered by
    // the regfile write-through, so it is never reported.
    function automatic int youngest_match(
        input hz_pos_t                  ent,
        input logic [HZ_ADDR_W_MAX-1:0] src,
        input logic                     used,
        input int                       depth,
        input bit                       zero_reg
    );
        int r;
        r = FWD_NONE;
        for (int p = HZ_DEPTH_MAX - 1; p >= 1; p--) begin
            if (p < depth && used && ent[p].valid && ent[p].reg_write &&
                ent[p].dst == src && !(zero_reg && src == '0))
                r = p;
        end
        return r;
    endfunction

endpackage

// File: rtl/hz_match_row.sv
// hz_match_row: per-operand scoreboard lookup (combinational).
//   src        source register address
//   used       operand is read
//   early      operand is consumed in ID
//   entries    scoreboard view, positions 1..HZ_DEPTH_MAX (unused slots zero)
//   match_pos  youngest matching position < DEPTH, 0 if none
//   load_haz   youngest match is a load whose data is not ready for EX use
//   early_haz  any forwardable match for an operand consumed in ID
module hz_match_row
    import pipe_pkg::*;
#(
    parameter int REG_ADDR_W = 4,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 2,
    parameter int ZERO_REG   = 1,
    parameter int SEL_W      = 2
) (
    input  logic [REG_ADDR_W-1:0] src,
    input  logic                  used,
    input  logic                  early,
    input  hz_pos_t               entries,
    output logic [SEL_W-1:0]      match_pos,
    output logic                  load_haz,
    output logic                  early_haz
);

    int   yp;
    logic yp_is_load;
    logic unused_entries;

    assign yp = youngest_match(entries, HZ_ADDR_W_MAX'(src), used, DEPTH, ZERO_REG != 0);
    assign match_pos = SEL_W'(yp);

    // Only the youngest writer matters: an older load shadowed by a younger
    // ALU writer of the same register never stalls.
    always_comb begin
        yp_is_load = 1'b0;
        for (int p = 1; p < HZ_DEPTH_MAX; p++) begin
            if (p == yp && p < LOAD_STAGE)
                yp_is_load = entries[p].is_load;
        end
    end

    assign load_haz       = !early && yp_is_load;
    assign early_haz      = early && (yp != FWD_NONE);
    assign unused_entries = ^entries;

endmodule

// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: scoreboard-based stall and forwarding control.
// Tracks in-flight writers in a DEPTH-entry shift register (pos1=EX .. posDEPTH=WB).
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   id_valid                         ID holds a real instruction
//   id_src_addr/used/early           per-operand source address, read enable, ID-consumed
//   id_dst_addr, id_reg_write        destination and write enable
//   id_mem_read                      instruction is a load
//   id_flag_read, id_flag_write      conditional branch reads flags / instruction sets flags
//   stall                            hold PC and IF/ID, bubble into EX (combinational)
//   ex_fwd_sel                       registered per-operand EX source, 0 = regfile data
// Optional (PIPE_HAZARD_STATS_EN): stat_stall_cnt, stat_fwd_cnt, saturating 16-bit.
module pipe_hazard_unit
    import pipe_pkg::*;
#(
    parameter int REG_ADDR_W = 4,
    parameter int NUM_SRC    = 2,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 2,
    parameter int FLAG_STAGE = 1,
    parameter int ZERO_REG   = 1,
    localparam int SEL_W     = $clog2(DEPTH)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          id_valid,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src_addr,
    input  logic [NUM_SRC-1:0]            id_src_used,
    input  logic [NUM_SRC-1:0]            id_src_early,
    input  logic [REG_ADDR_W-1:0]         id_dst_addr,
    input  logic                          id_reg_write,
    input  logic                          id_mem_read,
    input  logic                          id_flag_read,
    input  logic                          id_flag_write,
    output logic                          stall,
    output logic [NUM_SRC*SEL_W-1:0]      ex_fwd_sel
`ifdef PIPE_HAZARD_STATS_EN
    ,
    output logic [15:0]                   stat_stall_cnt,
    output logic [15:0]                   stat_fwd_cnt
`endif
);

    hz_entry_t [DEPTH:1]        pos_q;
    hz_pos_t                    pos_view;
    hz_entry_t                  new_entry;
    logic [NUM_SRC*SEL_W-1:0]   match_pos;
    logic [NUM_SRC-1:0]         load_haz;
    logic [NUM_SRC-1:0]         early_haz;
    logic                       flag_haz;

    // Fixed-size view for the lookup rows; slots beyond DEPTH read as empty.
    for (genvar p = 1; p <= HZ_DEPTH_MAX; p++) begin : g_view
        if (p <= DEPTH) begin : g_live
            assign pos_view[p] = pos_q[p];
        end else begin : g_empty
            assign pos_view[p] = '0;
        end
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_row
        hz_match_row #(
            .REG_ADDR_W (REG_ADDR_W),
            .DEPTH      (DEPTH),
            .LOAD_STAGE (LOAD_STAGE),
            .ZERO_REG   (ZERO_REG),
            .SEL_W      (SEL_W)
        ) u_row (
            .src       (id_src_addr[i*REG_ADDR_W +: REG_ADDR_W]),
            .used      (id_src_used[i]),
            .early     (id_src_early[i]),
            .entries   (pos_view),
            .match_pos (match_pos[i*SEL_W +: SEL_W]),
            .load_haz  (load_haz[i]),
            .early_haz (early_haz[i])
        );
    end

    always_comb begin
        flag_haz = 1'b0;
        for (int p = 1; p <= DEPTH; p++) begin
            if (p <= FLAG_STAGE && pos_q[p].valid && pos_q[p].flag_write)
                flag_haz = 1'b1;
        end
    end

    assign stall = id_valid && ((|load_haz) || (|early_haz) || (id_flag_read && flag_haz));

    always_comb begin
        new_entry            = '0;
        new_entry.valid      = 1'b1;
        new_entry.dst        = HZ_ADDR_W_MAX'(id_dst_addr);
        new_entry.reg_write  = id_reg_write;
        new_entry.is_load    = id_mem_read;
        new_entry.flag_write = id_flag_write;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q      <= '0;
            ex_fwd_sel <= '0;
        end else begin
            for (int p = 2; p <= DEPTH; p++)
                pos_q[p] <= pos_q[p-1];
            if (stall || !id_valid) begin
                pos_q[1]   <= '0;
                ex_fwd_sel <= '0;
            end else begin
                pos_q[1]   <= new_entry;
                ex_fwd_sel <= match_pos;
            end
        end
    end

`ifdef PIPE_HAZARD_STATS_EN
    int          n_fwd;
    logic [16:0] fwd_sum;

    always_comb begin
        n_fwd = 0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (match_pos[i*SEL_W +: SEL_W] != '0)
                n_fwd = n_fwd + 1;
        end
    end

    assign fwd_sum = {1'b0, stat_fwd_cnt} + 17'(n_fwd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_stall_cnt <= '0;
            stat_fwd_cnt   <= '0;
        end else begin
            if (stall && stat_stall_cnt != 16'hFFFF)
                stat_stall_cnt <= stat_stall_cnt + 16'd1;
            if (id_valid && !stall)
                stat_fwd_cnt <= fwd_sum[16] ? 16'hFFFF : fwd_sum[15:0];
        end
    end
`endif

endmodule
